// File: rtl/load_pkg.sv
// Shared load-path definitions: mode encodings and small decode helpers used by
// the load formatter and anything else that needs to size or extend load data.
package load_pkg;

  typedef enum logic [2:0] {
    LD_LB   = 3'b000,
    LD_LBU  = 3'b001,
    LD_LH   = 3'b010,
    LD_LHU  = 3'b011,
    LD_LW   = 3'b100,
    LD_LWU  = 3'b101,
    LD_LD   = 3'b110,
    LD_RSVD = 3'b111
  } ld_mode_e;

  // Access size in bytes; the reserved mode reports zero.
  function automatic logic [3:0] ld_size_bytes(input ld_mode_e mode);
    case (mode)
      LD_LB, LD_LBU: return 4'd1;
      LD_LH, LD_LHU: return 4'd2;
      LD_LW, LD_LWU: return 4'd4;
      LD_LD:         return 4'd8;
      default:       return 4'd0;
    endcase
  endfunction

  // True for the sign-extending loads; LD fills the whole word so it is neither.
  function automatic logic ld_is_signed(input ld_mode_e mode);
    return (mode == LD_LB) || (mode == LD_LH) || (mode == LD_LW);
  endfunction

endpackage

// File: rtl/load_extend_comb.sv
// Combinational extender: takes a right-justified field and a load mode and
// produces the zero- or sign-extended result. Flagged entries yield zero.
module load_extend_comb
  import load_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] field,
  input  logic [2:0]            mode,
  input  logic                  misaligned,
  input  logic                  illegal,
  output logic [DATA_WIDTH-1:0] data
);

  ld_mode_e mode_e;
  logic     sgn;

  assign mode_e = ld_mode_e'(mode);

  // Fill the upper bits with the sign (or zero), then overlay the selected field.
  always_comb begin
    data = '0;
    sgn  = ld_is_signed(mode_e);
    if (!(misaligned || illegal)) begin
      case (ld_size_bytes(mode_e))
        4'd1: begin
          data      = {DATA_WIDTH{sgn & field[7]}};
          data[7:0] = field[7:0];
        end
        4'd2: begin
          data       = {DATA_WIDTH{sgn & field[15]}};
          data[15:0] = field[15:0];
        end
        4'd4: begin
          // At 32 bits this is the full word and the fill is overwritten.
          data       = {DATA_WIDTH{sgn & field[31]}};
          data[31:0] = field[31:0];
        end
        4'd8:    data = field;
        default: data = '0;
      endcase
    end
  end

endmodule

// File: rtl/load_extend_pipe.sv
// Two-stage load-data formatter for the MEM/WB boundary. Stage 1 aligns the
// addressed field and classifies the access; stage 2 extends it and holds the
// result until the consumer takes it. Valid/ready handshake on both sides.
module load_extend_pipe
  import load_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5,
  localparam int OFF_W     = $clog2(DATA_WIDTH / 8)
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Flush,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [DATA_WIDTH-1:0] InData,
  input  logic [OFF_W-1:0]      InOffset,
  input  logic [2:0]            InMode,
  input  logic [TAG_WIDTH-1:0]  InTag,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [DATA_WIDTH-1:0] OutData,
  output logic [TAG_WIDTH-1:0]  OutTag,
  output logic                  OutMisaligned,
  output logic                  OutIllegal
);

  // Stage 1 state
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_field;
  logic [2:0]            s1_mode;
  logic [TAG_WIDTH-1:0]  s1_tag;
  logic                  s1_misaligned;
  logic                  s1_illegal;

  // Stage 2 state (drives the outputs directly so they hold while stalled)
  logic                  s2_valid;
  logic [DATA_WIDTH-1:0] s2_data;
  logic [TAG_WIDTH-1:0]  s2_tag;
  logic                  s2_misaligned;
  logic                  s2_illegal;

  // Input-side decode
  ld_mode_e              in_mode_e;
  logic [3:0]            in_size;
  logic [OFF_W-1:0]      in_align_mask;
  logic                  in_illegal;
  logic                  in_misaligned;
  logic [DATA_WIDTH-1:0] in_field;

  logic                  s1_advance;
  logic                  s2_advance;
  logic [DATA_WIDTH-1:0] ext_data;

  assign in_mode_e     = ld_mode_e'(InMode);
  assign in_size       = ld_size_bytes(in_mode_e);
  assign in_align_mask = OFF_W'(in_size - 4'd1);
  assign in_field      = InData >> {InOffset, 3'b000};

  // Illegal wins over misaligned so at most one flag is raised.
  assign in_illegal    = (in_mode_e == LD_RSVD) ||
                         ((DATA_WIDTH == 32) && ((in_mode_e == LD_LD) || (in_mode_e == LD_LWU)));
  assign in_misaligned = !in_illegal && ((InOffset & in_align_mask) != '0);

  // Stage 2 frees up when empty or when the consumer takes the result; stage 1
  // can always move when stage 2 moves. InReady is thus combinational in OutReady.
  assign s2_advance = !s2_valid || OutReady;
  assign s1_advance = s2_advance;
  assign InReady    = !s1_valid || s1_advance;

  load_extend_comb #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_extend (
    .field     (s1_field),
    .mode      (s1_mode),
    .misaligned(s1_misaligned),
    .illegal   (s1_illegal),
    .data      (ext_data)
  );

  // Stage 1: capture the aligned field and classification on input transfer.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      s1_valid      <= 1'b0;
      s1_field      <= '0;
      s1_mode       <= 3'b000;
      s1_tag        <= '0;
      s1_misaligned <= 1'b0;
      s1_illegal    <= 1'b0;
    end else if (Flush) begin
      s1_valid <= 1'b0;
    end else if (InReady) begin
      s1_valid <= InValid;
      if (InValid) begin
        s1_field      <= in_field;
        s1_mode       <= InMode;
        s1_tag        <= InTag;
        s1_misaligned <= in_misaligned;
        s1_illegal    <= in_illegal;
      end
    end
  end

  // Stage 2: register the extended result; payload only changes on a new entry.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      s2_valid      <= 1'b0;
      s2_data       <= '0;
      s2_tag        <= '0;
      s2_misaligned <= 1'b0;
      s2_illegal    <= 1'b0;
    end else if (Flush) begin
      s2_valid <= 1'b0;
    end else if (s2_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data       <= ext_data;
        s2_tag        <= s1_tag;
        s2_misaligned <= s1_misaligned;
        s2_illegal    <= s1_illegal;
      end
    end
  end

  assign OutValid      = s2_valid;
  assign OutData       = s2_data;
  assign OutTag        = s2_tag;
  assign OutMisaligned = s2_misaligned;
  assign OutIllegal    = s2_illegal;

endmodule
